fifo_byte_serializer: RTL and testbench
=======================================

Name: fifo_byte_serializer

Overview:
- Downstream consumer of the 32-bit, 16-deep FIFO.
- Pops one word at a time using the FIFO's show-ahead read interface (read-data presents the head word combinationally; the read pulse advances the head at the clock edge).
- Emits each word as 4 bytes on a valid/ready byte stream toward the byte-wide transmit stage.
- Checks the FIFO's registered read-acknowledge/read-error flags and keeps a saturating word counter.

Parameters:
- MSB_FIRST, 1: 1 = byte 3 (bits 31:24) is sent first; 0 = byte 0 (bits 7:0) is sent first.
- CNT_W, 16: width of the words_sent counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  pop enable; when 0, no new word is popped, and a word in flight still completes.
- fifo_dout  in  32  FIFO head word (show-ahead).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_ack  in  1  FIFO read acknowledge, one cycle after a successful pop.
- fifo_rd_err  in  1  FIFO read error, one cycle after a pop of an empty FIFO.
- fifo_read  out  1  pop request to the FIFO; never asserted together with a write by this block.
- m_valid  out  1  byte available.
- m_data  out  8  byte value.
- m_ready  in  1  downstream accepts the byte when m_valid && m_ready at a rising edge.
- busy  out  1  1 while a word is held (state SEND).
- err  out  1  sticky protocol error.
- err_clr  in  1  synchronous clear of err.
- words_sent  out  CNT_W  count of fully transmitted words, saturating at all-ones.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE; shift register = 0; byte index = 0; m_valid = 0; m_data = 0; err = 0; words_sent = 0; pending-ack flag = 0.
  - fifo_read is forced to 0 while rst_n = 0.
- State IDLE:
  - fifo_read = en && !fifo_empty. This is combinational, so the FIFO and this block act on the same edge.
  - When fifo_read = 1 at an edge: capture fifo_dout into the word register, set byte index = 0, set pending-ack = 1, go to SEND.
- State SEND:
  - m_valid = 1; m_data = the byte selected by the byte index and MSB_FIRST. m_data is held stable while m_valid && !m_ready.
  - Handshake at an edge with the byte index < 3: increment the byte index.
  - Handshake at an edge with the byte index = 3 (last byte): words_sent increments (saturating).
    - If en && !fifo_empty: fifo_read = 1 in that same cycle; load the next word, byte index = 0, remain in SEND. This is a back-to-back chain with no bubble, for a throughput of 1 byte/cycle.
    - Otherwise: go to IDLE with m_valid = 0.
  - fifo_read is 0 in SEND except during that last-byte handshake.
- Latency: fifo_empty falling in cycle t → fifo_read high in cycle t → first byte has m_valid in cycle t+1.
- Ack checking, one cycle after each pop:
  - Expect fifo_rd_ack = 1 and fifo_rd_err = 0.
  - Any other combination sets err.
  - fifo_rd_err = 1 at any time sets err.
  - fifo_rd_ack = 1 with no pending pop sets err.
  - The pending flag clears after the check cycle.
- err priority: err_clr clears err unless a new error occurs in the same cycle; set wins.
- m_ready is ignored when m_valid = 0.
- en falling mid-word: the current word finishes; no further pops.
- FIFO empty at the end of a word: return to IDLE; no pop of an empty FIFO ever occurs.
- Reset mid-word: the word is discarded, outputs return to reset values at once, and the FIFO contents are not touched.

Test Plan:
- Reset, then write 0xA1B2C3D4, en = 1, m_ready = 1 → fifo_read pulses for 1 cycle; bytes A1, B2, C3, D4 on consecutive cycles; words_sent = 1; err = 0.
- MSB_FIRST = 0, same word → bytes D4, C3, B2, A1.
- FIFO preloaded with 16 words, m_ready = 1 → 64 consecutive valid cycles with no bubble; exactly 16 fifo_read pulses, each coincident with a last-byte handshake; FIFO ends empty; words_sent = 16.
- m_ready toggled randomly (for example, low for 3 cycles on byte 2) → m_data held stable while stalled; byte order is preserved and no bytes are lost.
- Mid-word: en dropped → the word completes and no further pop occurs. Separately, rst_n pulsed after byte 1 → m_valid = 0 immediately; afterwards the next FIFO word is sent from byte 0.
- Force fifo_rd_err = 1, or withhold fifo_rd_ack after a pop → err = 1 and stays set; assert err_clr → err = 0 the next cycle.

Source files
------------

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer: pops 32-bit words from a show-ahead FIFO
// and streams each one as four bytes on a valid/ready interface.
module fifo_byte_serializer #(
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [31:0]      fifo_dout,
   input  logic             fifo_empty,
   input  logic             fifo_rd_ack,
   input  logic             fifo_rd_err,
   output logic             fifo_read,
   output logic             m_valid,
   output logic [7:0]       m_data,
   input  logic             m_ready,
   output logic             busy,
   output logic             err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] words_sent
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t      state;
   logic [31:0] sh;
   logic [31:0] sh_nx;
   logic [1:0]  idx;
   logic        pend;
   logic        last_hs;
   logic        err_set;

   function automatic logic [7:0] head(input logic [31:0] w);
      return MSB_FIRST ? w[31:24] : w[7:0];
   endfunction

   assign last_hs = (state == SEND) && m_valid && m_ready
                    && (idx == 2'd3);

   // Pop in IDLE, or on the last byte's handshake to chain words.
   assign fifo_read = rst_n && en && !fifo_empty
                      && ((state == IDLE) || last_hs);

   assign sh_nx = MSB_FIRST ? {sh[23:0], 8'h00}
                            : {8'h00, sh[31:8]};

   assign busy = (state == SEND);

   // Exactly one ack, and no error, must follow every pop.
   assign err_set = fifo_rd_err
                    | (pend ? !fifo_rd_ack : fifo_rd_ack);

   // Word load, byte stepping, chaining and the sent-word counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sh         <= '0;
         idx        <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         words_sent <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (fifo_read) begin
                  sh      <= fifo_dout;
                  m_data  <= head(fifo_dout);
                  idx     <= '0;
                  m_valid <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (m_ready) begin
                  if (idx != 2'd3) begin
                     idx    <= idx + 2'd1;
                     sh     <= sh_nx;
                     m_data <= head(sh_nx);
                  end else begin
                     if (words_sent != {CNT_W{1'b1}})
                        words_sent <= words_sent
                                      + {{(CNT_W-1){1'b0}}, 1'b1};
                     if (fifo_read) begin
                        sh     <= fifo_dout;
                        m_data <= head(fifo_dout);
                        idx    <= '0;
                     end else begin
                        sh      <= '0;
                        m_data  <= '0;
                        idx     <= '0;
                        m_valid <= 1'b0;
                        state   <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Remember that a pop happened so its ack can be checked next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend <= 1'b0;
      else        pend <= fifo_read;
   end

   // Sticky error flag; a new error beats a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       err <= 1'b0;
      else if (err_set) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
   end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb_fifo_byte_serializer: FIFO model plus byte-stream scoreboard
// driving an MSB-first and an LSB-first (narrow counter) instance.
module tb_fifo_byte_serializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        m_ready = 1'b0;
   logic        err_clr = 1'b0;
   logic [31:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_rd_ack = 1'b0;
   logic        fifo_rd_err = 1'b0;

   logic        fifo_read, m_valid, busy, err;
   logic [7:0]  m_data;
   logic [15:0] words_sent;
   logic        fifo_read_l, m_valid_l, busy_l, err_l;
   logic [7:0]  m_data_l;
   logic [2:0]  words_sent_l;

   always #5 clk = ~clk;

   fifo_byte_serializer #(.MSB_FIRST(1'b1), .CNT_W(16)) u_msb (
      .clk(clk), .rst_n(rst_n), .en(en),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
      .fifo_read(fifo_read), .m_valid(m_valid), .m_data(m_data),
      .m_ready(m_ready), .busy(busy), .err(err),
      .err_clr(err_clr), .words_sent(words_sent)
   );

   fifo_byte_serializer #(.MSB_FIRST(1'b0), .CNT_W(3)) u_lsb (
      .clk(clk), .rst_n(rst_n), .en(en),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
      .fifo_read(fifo_read_l), .m_valid(m_valid_l), .m_data(m_data_l),
      .m_ready(m_ready), .busy(busy_l), .err(err_l),
      .err_clr(err_clr), .words_sent(words_sent_l)
   );

   // ---------------- show-ahead FIFO model ----------------
   logic [31:0] mem [16];
   logic [3:0]  rdp = '0;
   logic [3:0]  wrp = '0;
   int          fifo_cnt = 0;
   int          pop_cnt = 0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        force_err = 1'b0;
   logic        withhold = 1'b0;
   logic        spur = 1'b0;
   logic        rd_ok, wr_ok;

   assign fifo_dout  = mem[rdp];
   assign fifo_empty = (fifo_cnt == 0);
   assign rd_ok = fifo_read && (fifo_cnt != 0);
   assign wr_ok = wr_en && ((fifo_cnt < 16) || rd_ok);

   always @(posedge clk) begin
      fifo_rd_ack <= (rd_ok && !withhold) || spur;
      fifo_rd_err <= force_err || (fifo_read && fifo_cnt == 0);
      if (rd_ok) begin
         rdp     <= rdp + 4'd1;
         pop_cnt <= pop_cnt + 1;
      end
      if (wr_ok) begin
         mem[wrp] <= wr_data;
         wrp      <= wrp + 4'd1;
      end
      fifo_cnt <= fifo_cnt + int'(wr_ok) - int'(rd_ok);
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference: bytes of every pushed word, in stream order.
   logic [7:0]  exp_m[$];
   logic [7:0]  exp_l[$];
   int          k = 0;
   bit          held = 0;
   int          exp_ws = 0;
   bit          stall = 0;
   logic [15:0] stall_d;
   logic [31:0] cur_m, cur_l, last_m, last_l;

   task automatic add_exp(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) exp_m.push_back(w[8*i +: 8]);
      for (int i = 0; i < 4; i++)  exp_l.push_back(w[8*i +: 8]);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_m_valid", m_valid, 0);
         chk("rst_m_data", m_data, 0);
         chk("rst_words", words_sent, 0);
         chk("rst_read", fifo_read, 0);
         chk("rst_busy", busy, 0);
         chk("rst_m_valid_l", m_valid_l, 0);
         if (held)
            for (int i = k; i < 4; i++) begin
               if (exp_m.size() > 0) void'(exp_m.pop_front());
               if (exp_l.size() > 0) void'(exp_l.pop_front());
            end
         held = 0; k = 0; exp_ws = 0; stall = 0;
      end else begin
         chk("m_valid", m_valid, held);
         chk("m_valid_l", m_valid_l, held);
         chk("busy", busy, held);
         chk("words_sent", words_sent, exp_ws);
         chk("words_sat", words_sent_l, exp_ws > 7 ? 7 : exp_ws);
         chk("read_match", fifo_read_l, fifo_read);
         if (stall && m_valid)
            chk("stall_hold", {m_data, m_data_l}, stall_d);
         stall   = m_valid && !m_ready;
         stall_d = {m_data, m_data_l};
         if (fifo_read) begin
            chk("pop_nonempty", fifo_empty, 0);
            if (held) chk("pop_on_last", {m_ready, k == 3}, 2'b11);
         end
         if (m_valid && m_ready) begin
            chk("byte_avail", exp_m.size() > 0, 1);
            if (exp_m.size() > 0) begin
               chk("byte_msb", m_data, exp_m.pop_front());
               chk("byte_lsb", m_data_l, exp_l.pop_front());
            end
            cur_m = {cur_m[23:0], m_data};
            cur_l = {cur_l[23:0], m_data_l};
            k++;
            if (k == 4) begin
               k = 0; held = 0; exp_ws++;
               last_m = cur_m; last_l = cur_l;
            end
         end
         if (fifo_read) held = 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      if (fifo_cnt < 16) begin
         wr_en = 1'b1; wr_data = w; add_exp(w);
      end
      step();
      wr_en = 1'b0;
   endtask

   task automatic drain(input string nm, input int budget);
      bit ok = 0;
      en = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (fifo_empty && !busy) begin ok = 1; break; end
      end
      chk(nm, ok, 1);
   endtask

   task automatic wait_valid(input string nm);
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_valid) begin ok = 1; break; end
      end
      chk(nm, ok, 1);
   endtask

   typedef struct {
      logic [31:0] w;
      logic [31:0] exp_m;
      logic [31:0] exp_l;
   } vec_t;

   vec_t tbl[4];
   int   p0, ws0, nv;

   initial begin
      tbl[0] = '{32'hA1B2C3D4, 32'hA1B2C3D4, 32'hD4C3B2A1};
      tbl[1] = '{32'h00000000, 32'h00000000, 32'h00000000};
      tbl[2] = '{32'hFFFF0001, 32'hFFFF0001, 32'h0100FFFF};
      tbl[3] = '{32'h12345678, 32'h12345678, 32'h78563412};

      #2 rst_n = 1'b0;
      repeat (3) step();
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      step();

      // single words, table driven
      for (int i = 0; i < 4; i++) begin
         p0 = pop_cnt;
         en = 1'b1; m_ready = 1'b1;
         push(tbl[i].w);
         drain("tbl_done", 20);
         chk("tbl_msb", last_m, tbl[i].exp_m);
         chk("tbl_lsb", last_l, tbl[i].exp_l);
         chk("tbl_pops", pop_cnt - p0, 1);
         chk("tbl_err", err, 0);
      end

      // full FIFO, back-to-back chain
      en = 1'b0;
      for (int i = 0; i < 16; i++) push(32'h10203040 + i * 32'h01010101);
      chk("burst_full", fifo_cnt, 16);
      p0 = pop_cnt; ws0 = exp_ws; nv = 0;
      en = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (m_valid) nv++;
         else if (nv > 0) break;
      end
      chk("burst_run", nv, 64);
      chk("burst_pops", pop_cnt - p0, 16);
      chk("burst_empty", fifo_cnt, 0);
      chk("burst_words", words_sent, ws0 + 16);
      step();

      // random traffic with stalls and en toggling
      for (int c = 0; c < 800; c++) begin
         m_ready = ($urandom % 4) != 0;
         en      = ($urandom % 8) != 0;
         if (fifo_cnt < 15 && ($urandom % 3) == 0) begin
            wr_data = $urandom; wr_en = 1'b1; add_exp(wr_data);
         end else begin
            wr_en = 1'b0;
         end
         step();
      end
      wr_en = 1'b0;
      drain("rand_drain", 400);
      chk("rand_left", exp_m.size(), 0);
      chk("rand_err", err, 0);

      // en dropped after the first byte
      en = 1'b0; m_ready = 1'b1;
      push(32'hCAFEF00D);
      push(32'h0BADBEEF);
      p0 = pop_cnt; ws0 = exp_ws;
      en = 1'b1;
      wait_valid("en_valid");
      step();
      en = 1'b0;
      repeat (10) step();
      chk("en_pops", pop_cnt - p0, 1);
      chk("en_words", words_sent, ws0 + 1);
      chk("en_busy", busy, 0);
      chk("en_left", fifo_cnt, 1);
      chk("en_word", last_m, 32'hCAFEF00D);
      drain("en_drain", 20);
      chk("en_word2", last_m, 32'h0BADBEEF);

      // reset after byte 1 of a word
      en = 1'b0;
      push(32'h5566AA77);
      push(32'h8899CCDD);
      en = 1'b1;
      wait_valid("rst_valid");
      step();
      step();
      rst_n = 1'b0;
      #1 chk("rst_async_valid", m_valid, 0);
      chk("rst_fifo_kept", fifo_cnt, 1);
      step();
      rst_n = 1'b1;
      drain("rst_drain", 20);
      chk("rst_next_word", last_m, 32'h8899CCDD);
      chk("rst_words_after", words_sent, 1);
      chk("rst_err_after", err, 0);

      // read error, then clear
      force_err = 1'b1; step(); force_err = 1'b0;
      repeat (3) step();
      chk("rderr_set", err, 1);
      repeat (4) step();
      chk("rderr_sticky", err_l, 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("rderr_clr", err, 0);

      // set beats clear in the same cycle
      force_err = 1'b1; step();
      force_err = 1'b0; err_clr = 1'b1; step();
      err_clr = 1'b0;
      chk("set_wins", err, 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("set_wins_clr", err, 0);

      // missing ack after a pop
      withhold = 1'b1;
      push(32'h01234567);
      drain("noack_drain", 20);
      withhold = 1'b0;
      chk("noack_err", err, 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("noack_clr", err, 0);

      // ack with no pop outstanding
      en = 1'b0;
      step();
      spur = 1'b1; step(); spur = 1'b0;
      repeat (2) step();
      chk("spur_err", err, 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("spur_clr", err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
